keypad_scanner: RTL

Drives a 4x4 matrix keypad and turns raw row/column contacts into one debounced key event per press. Sits in front of `keypad_decoder` in the calculator datapath and supplies its `key_test`/`trigger` pair. Column strobing, row synchronisation, ghost rejection, press/release debouncing and single-cycle event generation all run in the 1 MHz clock domain.

---
 rtl/keypad_scanner.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, row sync, ghost rejection, press/release debounce.
// One registered key_trigger pulse per accepted press; key_code/key_held update in the same cycle.
module keypad_scanner #(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [7:0] key_code,
    output logic       key_trigger,
    output logic       key_held
);

    localparam int SW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [SW-1:0] SLOT_LAST = SW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DB_MAX    = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE       = CW'(1);

    typedef enum logic [1:0] {IDLE, PRESS_DB, HELD, REL_DB} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   cnt, cnt_nxt, cnt_inc;
    logic [7:0]      cand, cand_nxt;
    logic [3:0]      sync1, sync2, row_s;
    logic [SW-1:0]   slot_cnt;
    logic [1:0]      col_idx;
    logic [2:0][3:0] samp;
    logic            slot_last, eval;
    logic [15:0]     scan;
    logic [7:0]      scan_code;
    logic            none, single;
    logic            do_accept, do_release;

    assign row_s     = ~sync2;
    assign slot_last = (slot_cnt == SLOT_LAST);
    assign eval      = slot_last && (col_idx == 2'd3);

    // Column 3's sample is taken from row_s directly so the scan is judged in its final cycle.
    assign scan      = {row_s, samp[2], samp[1], samp[0]};
    assign none      = (scan == 16'h0000);
    assign single    = $onehot(scan);
    assign scan_code = {row_s | samp[2] | samp[1] | samp[0],
                        |row_s, |samp[2], |samp[1], |samp[0]};
    assign cnt_inc   = (cnt >= DB_MAX) ? cnt : cnt + ONE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= 4'hF;
            sync2    <= 4'hF;
            slot_cnt <= '0;
            col_idx  <= 2'd0;
            col_n    <= 4'b1110;
            samp     <= '0;
        end else begin
            sync1 <= row_n;
            sync2 <= sync1;
            if (slot_last) begin
                slot_cnt <= '0;
                col_idx  <= col_idx + 2'd1;
                col_n    <= ~(4'b0001 << (col_idx + 2'd1));
                case (col_idx)
                    2'd0:    samp[0] <= row_s;
                    2'd1:    samp[1] <= row_s;
                    2'd2:    samp[2] <= row_s;
                    default: ;
                endcase
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            cand        <= 8'h00;
            key_code    <= 8'h00;
            key_trigger <= 1'b0;
            key_held    <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            cand        <= cand_nxt;
            key_trigger <= do_accept;
            if (do_accept) begin
                key_code <= scan_code;
                key_held <= 1'b1;
            end else if (do_release) begin
                key_held <= 1'b0;
            end
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        cand_nxt   = cand;
        do_accept  = 1'b0;
        do_release = 1'b0;
        if (eval) begin
            case (state)
                IDLE: begin
                    if (single) begin
                        cand_nxt = scan_code;
                        cnt_nxt  = ONE;
                        if (ONE >= DB_MAX) do_accept = 1'b1;
                        else               state_nxt = PRESS_DB;
                    end
                end
                PRESS_DB: begin
                    if (!single) begin
                        state_nxt = IDLE;
                        cnt_nxt   = '0;
                    end else if (scan_code == cand) begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= DB_MAX) do_accept = 1'b1;
                    end else begin
                        cand_nxt = scan_code;
                        cnt_nxt  = ONE;
                        if (ONE >= DB_MAX) do_accept = 1'b1;
                    end
                end
                // Anything but an empty scan is ignored here: no rollover, no second event.
                HELD: begin
                    if (none) begin
                        cnt_nxt = ONE;
                        if (ONE >= DB_MAX) do_release = 1'b1;
                        else               state_nxt  = REL_DB;
                    end
                end
                REL_DB: begin
                    if (!none) begin
                        state_nxt = HELD;
                    end else begin
                        cnt_nxt = cnt_inc;
                        if (cnt_inc >= DB_MAX) do_release = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
            if (do_accept) begin
                state_nxt = HELD;
                cnt_nxt   = '0;
            end
            if (do_release) begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        end
    end

endmodule
